// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter between writeback and the MDU
//
// Ports:
//   clock, reset                      single clock, synchronous active-high reset
//   wb_data_in/wb_dreg_in/wb_valid_in writeback write request (no backpressure except stall)
//   mdu_data_in/mdu_dreg_in/
//   mdu_valid_in/mdu_ready_out        MDU result push into the 2-entry FIFO
//   reg_add/reg_data/reg_wr           registered register file write port
//   pipe_stall_out                    freezes the pipeline for one forced FIFO drain
//   pending_mask                      one bit per register targeted by a queued MDU result
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] wb_data_in,
    input  logic [4:0]  wb_dreg_in,
    input  logic        wb_valid_in,
    input  logic [31:0] mdu_data_in,
    input  logic [4:0]  mdu_dreg_in,
    input  logic        mdu_valid_in,
    output logic        mdu_ready_out,
    output logic [4:0]  reg_add,
    output logic [31:0] reg_data,
    output logic        reg_wr,
    output logic        pipe_stall_out,
    output logic [31:0] pending_mask
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Entry 0 is always the head; entry 1 is valid only when count == 2.
    logic [4:0]  q_dreg [2];
    logic [31:0] q_data [2];
    logic [1:0]  count;
    logic [3:0]  age;

    logic       steal;
    logic       pop;
    logic       grant_wb;
    logic       push;
    logic [1:0] count_next;
    logic [1:0] slot_calc;
    logic       wr_slot;

    // Everything that gates the pipeline comes from registered state only,
    // so the stall never depends on this cycle's writeback request.
    assign steal          = (count == 2'd2) || ((count != 2'd0) && (age >= LIMIT));
    assign pipe_stall_out = steal;
    assign mdu_ready_out  = (count < 2'd2);

    always_comb begin
        pop        = steal || (!wb_valid_in && (count != 2'd0));
        grant_wb   = !steal && wb_valid_in;
        push       = mdu_valid_in && mdu_ready_out;
        count_next = count + {1'b0, push} - {1'b0, pop};
        // A push lands behind whatever remains after this cycle's pop.
        slot_calc  = count - {1'b0, pop};
        wr_slot    = slot_calc[0];
    end

    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (count > 2'(i)) begin
                pending_mask[q_dreg[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                q_dreg[i] <= 5'd0;
                q_data[i] <= 32'd0;
            end
            count    <= 2'd0;
            age      <= 4'd0;
            reg_add  <= 5'd0;
            reg_data <= 32'd0;
            reg_wr   <= 1'b0;
        end else begin
            if (pop) begin
                q_dreg[0] <= q_dreg[1];
                q_data[0] <= q_data[1];
            end
            // Placed after the shift so a push into slot 0 overrides it.
            if (push) begin
                q_dreg[wr_slot] <= mdu_dreg_in;
                q_data[wr_slot] <= mdu_data_in;
            end
            count <= count_next;

            // A new head always starts aging from zero.
            if (pop || (count == 2'd0)) begin
                age <= 4'd0;
            end else if (age < LIMIT) begin
                age <= age + 4'd1;
            end

            // Register 0 writes still consume the grant but never assert reg_wr.
            if (pop) begin
                reg_add  <= q_dreg[0];
                reg_data <= q_data[0];
                reg_wr   <= (q_dreg[0] != 5'd0);
            end else if (grant_wb) begin
                reg_add  <= wb_dreg_in;
                reg_data <= wb_data_in;
                reg_wr   <= (wb_dreg_in != 5'd0);
            end else begin
                reg_wr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard testbench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] wb_data_in;
    logic [4:0]  wb_dreg_in;
    logic        wb_valid_in;
    logic [31:0] mdu_data_in;
    logic [4:0]  mdu_dreg_in;
    logic        mdu_valid_in;
    logic        mdu_ready_out;
    logic [4:0]  reg_add;
    logic [31:0] reg_data;
    logic        reg_wr;
    logic        pipe_stall_out;
    logic [31:0] pending_mask;

    rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .wb_data_in     (wb_data_in),
        .wb_dreg_in     (wb_dreg_in),
        .wb_valid_in    (wb_valid_in),
        .mdu_data_in    (mdu_data_in),
        .mdu_dreg_in    (mdu_dreg_in),
        .mdu_valid_in   (mdu_valid_in),
        .mdu_ready_out  (mdu_ready_out),
        .reg_add        (reg_add),
        .reg_data       (reg_data),
        .reg_wr         (reg_wr),
        .pipe_stall_out (pipe_stall_out),
        .pending_mask   (pending_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  add;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.add  = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every asserted write must match the oldest expected write.
    always @(negedge clock) begin
        if (reg_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got add=%0d data=%h, required no write", reg_add, reg_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                n_cmp++;
                if (reg_add !== w.add || reg_data !== w.data) begin
                    n_fail++;
                    $display("FAIL write_order: got add=%0d data=%h, required add=%0d data=%h",
                             reg_add, reg_data, w.add, w.data);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        wb_data_in   = 32'd0;
        wb_dreg_in   = 5'd0;
        wb_valid_in  = 1'b0;
        mdu_data_in  = 32'd0;
        mdu_dreg_in  = 5'd0;
        mdu_valid_in = 1'b0;
        tick();
        tick();
        chk("rst_reg_wr",   32'(reg_wr), 32'd0);
        chk("rst_reg_add",  32'(reg_add), 32'd0);
        chk("rst_reg_data", reg_data, 32'd0);
        chk("rst_stall",    32'(pipe_stall_out), 32'd0);
        chk("rst_mask",     pending_mask, 32'd0);
        chk("rst_ready",    32'(mdu_ready_out), 32'd1);
        reset = 1'b0;
        tick();

        // Writeback only, then a suppressed write to register 0
        wb_valid_in = 1'b1; wb_dreg_in = 5'd5; wb_data_in = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        chk("t1_wr",   32'(reg_wr), 32'd1);
        chk("t1_add",  32'(reg_add), 32'd5);
        chk("t1_data", reg_data, 32'hDEADBEEF);
        wb_dreg_in = 5'd0; wb_data_in = 32'h11111111;
        tick();
        chk("t1_r0_wr", 32'(reg_wr), 32'd0);
        wb_valid_in = 1'b0;
        tick();
        chk("t1_idle_wr", 32'(reg_wr), 32'd0);

        // MDU into an idle port
        mdu_valid_in = 1'b1; mdu_dreg_in = 5'd7; mdu_data_in = 32'h12345678;
        expect_wr(5'd7, 32'h12345678);
        tick();
        mdu_valid_in = 1'b0;
        chk("t2_mask", pending_mask, 32'h0000_0080);
        chk("t2_nowr", 32'(reg_wr), 32'd0);
        tick();
        chk("t2_wr",      32'(reg_wr), 32'd1);
        chk("t2_add",     32'(reg_add), 32'd7);
        chk("t2_mask_clr", pending_mask, 32'd0);
        tick();

        // Starvation: writeback held busy, one MDU push
        wb_valid_in = 1'b1; wb_dreg_in = 5'd3; wb_data_in = 32'hA000_0000;
        mdu_valid_in = 1'b1; mdu_dreg_in = 5'd9; mdu_data_in = 32'h99;
        expect_wr(5'd3, 32'hA000_0000);
        tick();
        mdu_valid_in = 1'b0;
        chk("t3_stall0", 32'(pipe_stall_out), 32'd0);
        chk("t3_mask",   pending_mask, 32'h0000_0200);
        for (int i = 1; i <= 4; i++) begin
            wb_data_in = 32'hA000_0000 + 32'(i);
            expect_wr(5'd3, 32'hA000_0000 + 32'(i));
            tick();
            chk("t3_stall", 32'(pipe_stall_out), (i == 4) ? 32'd1 : 32'd0);
        end
        wb_data_in = 32'hA000_0005;
        expect_wr(5'd9, 32'h99);
        tick();
        chk("t3_stall_end", 32'(pipe_stall_out), 32'd0);
        chk("t3_add9",      32'(reg_add), 32'd9);
        chk("t3_mask_clr",  pending_mask, 32'd0);
        expect_wr(5'd3, 32'hA000_0005);
        tick();
        chk("t3_held_add",  32'(reg_add), 32'd3);
        chk("t3_held_data", reg_data, 32'hA000_0005);
        wb_valid_in = 1'b0;
        tick();

        // FIFO full: back-to-back pushes while writeback is busy
        wb_valid_in = 1'b1; wb_dreg_in = 5'd4; wb_data_in = 32'hB000_0000;
        mdu_valid_in = 1'b1; mdu_dreg_in = 5'd10; mdu_data_in = 32'h100;
        expect_wr(5'd4, 32'hB000_0000);
        tick();
        mdu_dreg_in = 5'd11; mdu_data_in = 32'h101;
        wb_data_in = 32'hB000_0001;
        expect_wr(5'd4, 32'hB000_0001);
        tick();
        chk("t4_ready0", 32'(mdu_ready_out), 32'd0);
        chk("t4_stall",  32'(pipe_stall_out), 32'd1);
        chk("t4_mask2",  pending_mask, 32'h0000_0C00);
        mdu_dreg_in = 5'd12; mdu_data_in = 32'h102;
        wb_data_in = 32'hB000_0002;
        expect_wr(5'd10, 32'h100);
        tick();
        chk("t4_ready1",   32'(mdu_ready_out), 32'd1);
        chk("t4_stall_lo", 32'(pipe_stall_out), 32'd0);
        chk("t4_mask1",    pending_mask, 32'h0000_0800);
        chk("t4_add10",    32'(reg_add), 32'd10);
        expect_wr(5'd4, 32'hB000_0002);
        tick();
        mdu_valid_in = 1'b0;
        wb_valid_in  = 1'b0;
        chk("t4_stall2", 32'(pipe_stall_out), 32'd1);
        chk("t4_mask3",  pending_mask, 32'h0000_1800);
        expect_wr(5'd11, 32'h101);
        tick();
        expect_wr(5'd12, 32'h102);
        tick();
        tick();
        chk("t4_mask_clr", pending_mask, 32'd0);

        // Simultaneous push and pop, then confirm the new head's age restarted
        mdu_valid_in = 1'b1; mdu_dreg_in = 5'd13; mdu_data_in = 32'h200;
        tick();
        mdu_dreg_in = 5'd14; mdu_data_in = 32'h201;
        expect_wr(5'd13, 32'h200);
        tick();
        mdu_valid_in = 1'b0;
        chk("t5_mask",  pending_mask, 32'h0000_4000);
        chk("t5_add",   32'(reg_add), 32'd13);
        chk("t5_stall", 32'(pipe_stall_out), 32'd0);
        chk("t5_ready", 32'(mdu_ready_out), 32'd1);
        wb_valid_in = 1'b1; wb_dreg_in = 5'd2;
        for (int i = 0; i < 4; i++) begin
            wb_data_in = 32'hC000_0000 + 32'(i);
            expect_wr(5'd2, 32'hC000_0000 + 32'(i));
            tick();
            chk("t5_age_stall", 32'(pipe_stall_out), (i == 3) ? 32'd1 : 32'd0);
        end
        wb_data_in = 32'hC000_0004;
        expect_wr(5'd14, 32'h201);
        tick();
        expect_wr(5'd2, 32'hC000_0004);
        tick();
        wb_valid_in = 1'b0;
        tick();
        chk("t5_mask_clr", pending_mask, 32'd0);

        // Reset with two queued entries and the stall raised
        wb_valid_in = 1'b1; wb_dreg_in = 5'd6; wb_data_in = 32'hD000_0000;
        mdu_valid_in = 1'b1; mdu_dreg_in = 5'd15; mdu_data_in = 32'h300;
        expect_wr(5'd6, 32'hD000_0000);
        tick();
        mdu_dreg_in = 5'd16; mdu_data_in = 32'h301;
        wb_data_in = 32'hD000_0001;
        expect_wr(5'd6, 32'hD000_0001);
        tick();
        mdu_valid_in = 1'b0;
        chk("t6_stall_pre", 32'(pipe_stall_out), 32'd1);
        reset = 1'b1;
        wb_valid_in = 1'b0;
        tick();
        chk("t6_reg_wr",   32'(reg_wr), 32'd0);
        chk("t6_reg_add",  32'(reg_add), 32'd0);
        chk("t6_reg_data", reg_data, 32'd0);
        chk("t6_stall",    32'(pipe_stall_out), 32'd0);
        chk("t6_mask",     pending_mask, 32'd0);
        chk("t6_ready",    32'(mdu_ready_out), 32'd1);
        reset = 1'b0;
        repeat (6) tick();
        chk("t6_no_stale", 32'(reg_wr), 32'd0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Writeback has priority. MDU results wait in a 2-entry FIFO. A starvation guard briefly stalls the pipeline to drain that FIFO. The block drives the register file write port (`reg_add`/`reg_data`/`reg_wr`) and exports a pending-write mask for decode hazard checks.

## Interface
- `STARVE_LIMIT`, default 4: cycles the FIFO head may wait before a pipeline stall is forced (1–15).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_data_in` in 32: writeback result.
- `wb_dreg_in` in 5: writeback destination register.
- `wb_valid_in` in 1: writeback requests the port this cycle; no backpressure except `pipe_stall_out`.
- `mdu_data_in` in 32: MDU result.
- `mdu_dreg_in` in 5: MDU destination register.
- `mdu_valid_in` in 1: MDU result offered.
- `mdu_ready_out` out 1: FIFO can accept; a push happens when `mdu_valid_in && mdu_ready_out`.
- `reg_add` out 5: register file write address.
- `reg_data` out 32: register file write data.
- `reg_wr` out 1: register file write enable.
- `pipe_stall_out` out 1: pipeline must freeze this cycle, holding its writeback inputs.
- `pending_mask` out 32: bit *i* is set when a FIFO entry targets register *i*.

## Operation
- **State:** 2-entry FIFO of {dreg, data}, `count` (0–2), and head-age counter `age`.
- **Steal condition:** `steal = (count==2) || (count!=0 && age>=STARVE_LIMIT)`.
  - `steal` is decoded from registered state only.
  - `pipe_stall_out = steal`.
- **Grant priority, evaluated each cycle:**
  1. If `steal`: grant the FIFO head and pop; `wb_valid_in` is ignored.
  2. Else if `wb_valid_in`: grant writeback.
  3. Else if `count!=0`: grant the FIFO head and pop.
  4. Else: no grant.
- **Output registers at the edge:**
  - On a grant, `reg_add`/`reg_data` load the granted dreg/data, and `reg_wr` is 1 unless the dreg is 0.
  - A write to register 0 is suppressed (`reg_wr=0`) but still consumes the grant and the pop.
  - With no grant, `reg_wr` is 0 and `reg_add`/`reg_data` hold their previous values.
- **MDU ready and push:**
  - `mdu_ready_out = (count<2)`, from registered state. It does not look ahead to a same-cycle pop.
  - A push and a pop in the same cycle are both performed: `count` is unchanged and the new entry goes in behind the head.
  - The FIFO keeps arrival order. An entry pushed at edge *k* is grant-eligible in the cycle after *k*.
- **Age counter:**
  - Cleared on reset, on any pop, and whenever `count==0`.
  - Otherwise increments by 1 per cycle while `count!=0`, saturating at `STARVE_LIMIT`.
  - After a pop with one entry remaining, that new head's age starts at 0.
- **`pending_mask`:**
  - Decoded from registered FIFO contents: OR of one-hot(dreg) over valid entries.
  - Bit 0 is forced to 0. Bit index equals register number.
  - A bit clears the cycle after the entry's pop edge.
- **Write ordering:** ordering between a writeback write and a queued MDU write to the same register is the decode stage's job, enforced via `pending_mask`. This block does not reorder.

## Timing
- Writeback latency is 1 cycle: inputs sampled at edge *k* appear on `reg_*` from edge *k* until edge *k+1*.
- MDU latency is at least 2 cycles: push at edge *k*, earliest write visible after edge *k+1*.
- **Stall cycle:**
  - `pipe_stall_out` is high for exactly one cycle per forced drain.
  - With `count==2` after a steal pop, it is high again the next cycle only if `count` returns to 2 or `age` reaches the limit.
- **Reset values:**
  - `reg_add=0`, `reg_data=0`, `reg_wr=0`.
  - `pipe_stall_out=0`, `pending_mask=0`, `mdu_ready_out=1`.
  - FIFO empty, `age=0`.
- **Reset mid-operation:** queued MDU results are discarded, and all outputs take their reset values after the reset edge.

## Test plan
1. **Writeback only:** reset, then `wb_valid_in=1`, `wb_dreg_in=5`, `wb_data_in=0xDEADBEEF` → next cycle `reg_wr=1`, `reg_add=5`, `reg_data=0xDEADBEEF`. Repeat with `wb_dreg_in=0` → `reg_wr=0`.
2. **MDU into idle port:** push dreg 7, data `0x12345678` with writeback idle.
   - `pending_mask[7]=1` for one cycle.
   - Write appears 2 cycles after the push edge.
   - Mask then clears.
3. **Starvation:** `wb_valid_in` held high and one MDU push to dreg 9, `STARVE_LIMIT=4`.
   - `pipe_stall_out=1` exactly 4 cycles after the push, for 1 cycle.
   - dreg 9 is written in that slot.
   - The held writeback request is written the following cycle.
4. **FIFO full:** two back-to-back pushes while writeback is busy.
   - `count=2`, `mdu_ready_out=0`, `pipe_stall_out=1` immediately.
   - A third `mdu_valid_in` is not accepted until `mdu_ready_out` returns to 1.
   - Order is preserved.
5. **Simultaneous push and pop:** `count=1`, writeback idle, MDU pushes → head written, new entry becomes head, `count` stays 1, `age` restarts at 0.
6. **Reset mid-operation:** assert `reset` with 2 queued entries and `pipe_stall_out` high → after the edge, all outputs at reset values, `pending_mask=0`, and no stale write appears afterward.
